filter_row_packer: RTL and testbench

Clocked upstream stage of the filter memory. Accepts a serial stream of filter weights and groups them into rows of KERNEL values. Emits one write packet per row in the filter-memory write format {done, fil_row, fil_data}, with done set on the final row so the memory unlocks its read port. Runs one complete filter load per start pulse.

---
 rtl/filter_row_packer.sv | 90 +++++++++
 tb/tb_filter_row_packer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_row_packer.sv
// Groups a serial stream of filter weights into KERNEL-wide rows and emits one
// filter-memory write packet {done, fil_row, fil_data} per row, one load per start.
module filter_row_packer #(
    parameter int unsigned FILTER_WIDTH = 8,
    parameter int unsigned KERNEL       = 5,
    parameter int unsigned WIDTH        = KERNEL * FILTER_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FILTER_WIDTH-1:0] in_data,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic [WIDTH+3:0]        pkt_data,
    output logic                    busy,
    output logic                    loaded
);

    localparam logic [2:0] LAST = 3'(KERNEL - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StSend, StDone} state_e;

    state_e             state_q, state_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         col_q, col_d;
    logic [WIDTH-1:0]   row_buf_q, row_buf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            row_buf_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            row_buf_q <= row_buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        row_buf_d = row_buf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StCollect;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StCollect: begin
                if (in_valid) begin
                    row_buf_d[col_q*FILTER_WIDTH +: FILTER_WIDTH] = in_data;
                    // col saturates at the last slot; SEND resets it for the next row
                    if (col_q == LAST) begin
                        state_d = StSend;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            StSend: begin
                if (pkt_ready) begin
                    if (row_q == LAST) begin
                        state_d = StDone;
                    end else begin
                        state_d = StCollect;
                        row_d   = row_q + 3'd1;
                        col_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from registered state; no path from in_valid or pkt_ready.
    assign in_ready  = (state_q == StCollect);
    assign pkt_valid = (state_q == StSend);
    assign busy      = (state_q == StCollect) || (state_q == StSend);
    assign loaded    = (state_q == StDone);
    assign pkt_data  = {row_q == LAST, row_q, row_buf_q};

endmodule

// File: tb/tb_filter_row_packer.sv
// Directed bench for filter_row_packer: full loads, back-pressure stall, input
// bubbles, mid-load reset and ignored start pulses, checked against hand values.
module tb_filter_row_packer;

    localparam int FW = 8;
    localparam int K  = 5;
    localparam int PW = K * FW + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_data;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [PW-1:0] pkt_data;
    logic          busy;
    logic          loaded;

    filter_row_packer #(
        .FILTER_WIDTH(FW),
        .KERNEL      (K)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .pkt_data (pkt_data),
        .busy     (busy),
        .loaded   (loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Hand-computed packets for weights 0x01..0x19.
    logic [PW-1:0] tab [5] = '{44'h00504030201, 44'h10A09080706, 44'h20F0E0D0C0B,
                               44'h31413121110, 44'hC1918171615};

    logic [PW-1:0] pkt_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [PW-1:0] model_pkt(input int base, input int row);
        logic [PW-1:0] p = '0;
        for (int j = 0; j < K; j++) p[j*FW +: FW] = 8'(base + row * K + j);
        p[PW-2 -: 3] = 3'(row);
        p[PW-1]      = (row == K - 1);
        return p;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: packet capture, latency and protocol properties.
    int acc_in_row   = 0;
    int last_acc_cyc = 0;
    int last_hs_cyc  = 0;
    bit prev_valid   = 0;
    bit wait_loaded  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_in_row  = 0;
            prev_valid  = 0;
            wait_loaded = 0;
        end else begin
            if (loaded && wait_loaded) begin
                check("loaded_latency", cyc, last_hs_cyc + 1);
                wait_loaded = 0;
            end
            if (pkt_valid && !prev_valid) check("pkt_latency", cyc, last_acc_cyc + 1);
            if (pkt_valid) begin
                check("no_overlap", in_valid && in_ready, 0);
                check("done_bit", pkt_data[PW-1], pkt_data[PW-2 -: 3] == 3'(K - 1));
            end
            if (pkt_valid && pkt_ready) begin
                pkt_q.push_back(pkt_data);
                last_hs_cyc = cyc;
                wait_loaded = pkt_data[PW-1];
            end
            if (in_valid && in_ready) begin
                acc_in_row++;
                if (acc_in_row == K) begin
                    acc_in_row   = 0;
                    last_acc_cyc = cyc;
                end
            end
            prev_valid = pkt_valid;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int count, input bit gaps);
        int i = 0;
        int budget = 0;
        while (i < count && budget < 2000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = 8'(first + i);
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0;
        check("feed_timeout", budget < 2000, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!loaded && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("load_timeout", loaded, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_load(input int base, input bit use_tab);
        check("pkt_count", pkt_q.size(), K);
        for (int r = 0; r < K && r < pkt_q.size(); r++)
            check($sformatf("pkt_row%0d", r), pkt_q[r], use_tab ? tab[r] : model_pkt(base, r));
        pkt_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_pkt_valid"}, pkt_valid, 0);
        check({tag, "_pkt_data"}, pkt_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_loaded"}, loaded, 0);
    endtask

    // Stall row 2 for 10 cycles with a start pulse inside SEND; start again on the final handshake.
    task automatic stall_driver();
        logic [PW-1:0] held;
        for (int r = 0; r < K; r++) begin
            int n = 0;
            @(negedge clk);
            while (!pkt_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("pkt_wait", pkt_valid, 1);
            if (r == 2) begin
                held = pkt_data;
                check("stall_first", held, tab[2]);
                for (int k = 0; k < 10; k++) begin
                    @(posedge clk); #1;
                    start = (k == 3);
                    @(negedge clk);
                    check("stall_valid", pkt_valid, 1);
                    check("stall_data", pkt_data, held);
                    check("stall_in_ready", in_ready, 0);
                end
            end
            @(posedge clk); #1;
            start     = (r == K - 1);
            pkt_ready = 1'b1;
            @(posedge clk); #1;
            start     = 1'b0;
            pkt_ready = 1'b0;
        end
    endtask

    task automatic collect_start();
        int n = 0;
        @(negedge clk);
        while (!(in_ready && !in_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("collect_bubble_found", n < 200, 1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; pkt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        // Straight-through load.
        pkt_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        check("start_in_ready", in_ready, 1);
        check("start_busy", busy, 1);
        @(posedge clk); #1;
        feed(1, 25, 0);
        wait_done();
        check("done_busy", busy, 0);
        check_load(1, 1);

        // Restart from DONE, back-pressure on row 2.
        pulse_start();
        @(negedge clk);
        check("restart_loaded_clr", loaded, 0);
        check("restart_busy", busy, 1);
        @(posedge clk); #1;
        pkt_ready = 1'b0;
        fork
            feed(1, 25, 0);
            stall_driver();
        join
        wait_done();
        repeat (2) @(negedge clk);
        check("final_hs_start_ignored", loaded, 1);
        check("final_hs_busy", busy, 0);
        @(posedge clk); #1;
        check_load(1, 1);

        // Random input bubbles, start pulsed during COLLECT.
        pkt_ready = 1'b1;
        pulse_start();
        fork
            feed(1, 25, 1);
            collect_start();
        join
        wait_done();
        check_load(1, 1);

        // Reset after three weights of row 1.
        pulse_start();
        feed(8'h21, K + 3, 0);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        check_zero("midreset_hold");
        rst_n = 1'b1;
        pkt_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_no_pkt", pkt_q.size(), 0);
        check("post_reset_busy", busy, 0);
        pulse_start();
        feed(8'h40, 25, 0);
        wait_done();
        check_load(8'h40, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
